fp_cmp_ctrl: RTL and testbench
==============================

Name: fp_cmp_ctrl

Overview:
Multi-cycle FP32 compare/min-max unit for the FPU execute stage. It sequences one shared 23-bit magnitude comparator over two phases: exponent first, then mantissa only when the exponents tie. Sign handling, zero handling and NaN handling are applied around the comparator. It implements RISC-V FEQ.S, FLT.S, FLE.S, FMIN.S and FMAX.S behind a valid/ready request and response handshake.

Parameters:
TAG_W, 5, width of the destination-register tag carried from request to response
CANON_NAN, 32'h7FC0_0000, result returned by FMIN/FMAX when both operands are NaN

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_req_valid  in  1  request valid
o_req_ready  out  1  unit can accept a request (high only in IDLE)
i_op  in  3  operation: 0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX; 5-7 reserved
i_rs1  in  32  operand A (IEEE-754 single)
i_rs2  in  32  operand B
i_tag  in  TAG_W  destination tag
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  consumer accepts response
o_rsp_data  out  32  result: compares give 0 or 1 zero-extended; min/max give an operand or CANON_NAN
o_rsp_tag  out  TAG_W  tag of the request
o_nv  out  1  invalid-operation flag for this response

Behaviour:
- Clock and reset:
  - Single clock domain on i_clk.
  - i_rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_tag=0, o_nv=0.
  - o_req_ready=1 from the first cycle after i_rst deasserts.
- Request handshake:
  - A request is accepted when i_req_valid && o_req_ready at a rising edge.
  - On acceptance, op, operands and tag are registered and the state moves to EXP.
- State EXP:
  - Comparator inputs are {15'b0, expA} and {15'b0, expB}.
  - Operands are classified combinationally: NaN, sNaN (exp=FF, mant!=0, mant[22]=0) and zero (exp=0, mant=0).
  - If any NaN is present, the signs differ, both operands are zero, or the exponents differ, the result is final and the state moves to RESP.
  - Otherwise the state moves to MAN.
- State MAN:
  - Comparator inputs are mantA and mantB.
  - The result is computed and the state moves to RESP.
- State RESP:
  - o_rsp_valid=1.
  - o_rsp_data, o_rsp_tag and o_nv are held stable until i_rsp_ready.
  - On i_rsp_ready the state moves to IDLE.
  - No bypass from RESP to accepting a new request: at most one request is in flight.
- Latency, with acceptance at edge k:
  - o_rsp_valid rises after edge k+2 when the result is decided in EXP.
  - o_rsp_valid rises after edge k+3 when the mantissa phase is needed.
- Ordering rules:
  - Magnitude is ordered by exponent, then mantissa. Denormals need no special path.
  - Signs differ, not both zero: the negative operand is less.
  - Both negative: the magnitude less/greater result is swapped.
  - +0 and -0 compare equal.
  - FMIN of ±0 pair returns 32'h8000_0000; FMAX of ±0 pair returns 32'h0000_0000.
- NaN rules:
  - FEQ with any NaN: result 0; o_nv=1 only if an sNaN is present.
  - FLT/FLE with any NaN: result 0, o_nv=1.
  - FMIN/FMAX with one NaN: return the other operand.
  - FMIN/FMAX with both NaN: return CANON_NAN.
  - FMIN/FMAX: o_nv=1 if any sNaN is present.
- Reserved op (5-7): responds in EXP timing with data=0 and o_nv=1.
- Reset mid-operation: any state goes to IDLE at the edge where i_rst is high. The pending result is discarded and o_rsp_valid=0 next cycle.
- The comparator is purely combinational; its outputs are consumed only in the EXP and MAN states.

Decomposition:
- Package fp_cmp_pkg contains:
  - op enum fp_cmp_op_e (FEQ, FLT, FLE, FMIN, FMAX)
  - state enum fp_cmp_state_e (IDLE, EXP, MAN, RESP)
  - constants FP_EXP_ALL1=8'hFF and CANON_NAN default
  - functions is_nan, is_snan, is_zero.
- Natural sub-module: fp_cmp_classify, a combinational operand classifier producing the nan, snan, zero and sign flags per operand.
- Exactly one 23-bit magnitude comparator instance is shared by both phases through an input mux driven by state.

Test Plan:
1. FLT 3F80_0000 vs 4000_0000 (exponents differ) -> o_rsp_valid 2 cycles after accept, data=1, nv=0, tag echoed.
2. FEQ 3F80_0001 vs 3F80_0000 (mantissa path) -> valid 3 cycles after accept, data=0. FLE with operands swapped -> data=1.
3. FLT BF80_0000 (-1) vs C000_0000 (-2) -> data=0. FMAX on the same pair -> BF80_0000. FMIN -> C000_0000.
4. FMIN 0000_0000 vs 8000_0000 -> 8000_0000. FEQ on the same pair -> 1, nv=0.
5. NaN cases:
   - FLE 7FC0_0000 vs 3F80_0000 -> data=0, nv=1.
   - FEQ 7F80_0001 vs 0000_0000 -> data=0, nv=1.
   - FMAX 7FC0_0000 vs 3F80_0000 -> 3F80_0000, nv=0.
   - FMIN of two qNaNs -> 7FC0_0000.
6. Backpressure and reset:
   - Hold i_rsp_ready=0 for 4 cycles -> data and tag stable, o_req_ready=0, new i_req_valid ignored.
   - Pulse i_rst during MAN -> next cycle o_rsp_valid=0, o_req_ready=1, no stale response afterwards.

Source files
------------

// File: rtl/fp_cmp_pkg.sv
// Shared types, constants and IEEE-754 single-precision helpers for the
// FP32 compare / min-max unit.
package fp_cmp_pkg;

  typedef enum logic [2:0] {
    OP_FEQ  = 3'd0,
    OP_FLT  = 3'd1,
    OP_FLE  = 3'd2,
    OP_FMIN = 3'd3,
    OP_FMAX = 3'd4
  } fp_cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXP,
    ST_MAN,
    ST_RESP
  } fp_cmp_state_e;

  localparam logic [7:0]  FP_EXP_ALL1  = 8'hFF;
  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  // Per-operand classification flags.
  typedef struct packed {
    logic nan;
    logic snan;
    logic zero;
    logic sign;
  } fp_class_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == FP_EXP_ALL1) && (v[22:0] != 23'd0);
  endfunction

  // Signalling NaN: quiet bit (mantissa MSB) clear, payload non-zero.
  function automatic logic is_snan(input logic [31:0] v);
    return is_nan(v) && !v[22];
  endfunction

  function automatic logic is_zero(input logic [31:0] v);
    return v[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fp_cmp_classify.sv
// Combinational classifier for one FP32 operand.
module fp_cmp_classify
  import fp_cmp_pkg::*;
(
  input  logic [31:0] operand,
  output fp_class_t   cls
);

  // Flag extraction is pure decode of the operand fields.
  always_comb begin
    cls.nan  = is_nan(operand);
    cls.snan = is_snan(operand);
    cls.zero = is_zero(operand);
    cls.sign = operand[31];
  end

endmodule

// File: rtl/fp_cmp_ctrl.sv
// Multi-cycle FP32 compare / min-max unit. One 23-bit magnitude comparator
// is shared between an exponent phase and an optional mantissa phase.
module fp_cmp_ctrl
  import fp_cmp_pkg::*;
#(
  parameter int          TAG_W     = 5,
  parameter logic [31:0] CANON_NAN = FP_CANON_NAN
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_nv
);

  fp_cmp_state_e    state_q, state_d;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;
  logic             nv_q;
  logic             valid_q;

  fp_class_t   cls_a, cls_b;
  logic [22:0] cmp_a, cmp_b;
  logic        mag_lt, mag_eq;
  logic        lt, eq;
  logic        any_nan, any_snan, both_nan, both_zero, sign_diff, reserved_op;
  logic        decided_exp;
  logic        accept, load;
  logic [31:0] res_data;
  logic        res_nv;

  fp_cmp_classify u_cls_a (.operand(a_q), .cls(cls_a));
  fp_cmp_classify u_cls_b (.operand(b_q), .cls(cls_b));

  assign any_nan     = cls_a.nan | cls_b.nan;
  assign any_snan    = cls_a.snan | cls_b.snan;
  assign both_nan    = cls_a.nan & cls_b.nan;
  assign both_zero   = cls_a.zero & cls_b.zero;
  assign sign_diff   = cls_a.sign ^ cls_b.sign;
  assign reserved_op = op_q > OP_FMAX;

  // Shared comparator: exponents in EXP, mantissas in MAN.
  always_comb begin
    if (state_q == ST_MAN) begin
      cmp_a = a_q[22:0];
      cmp_b = b_q[22:0];
    end else begin
      cmp_a = {15'd0, a_q[30:23]};
      cmp_b = {15'd0, b_q[30:23]};
    end
    mag_lt = cmp_a < cmp_b;
    mag_eq = cmp_a == cmp_b;
  end

  // Signed ordering built from the magnitude result; negatives swap order.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lt = 1'b0;
    eq = 1'b0;
    if (both_zero)      eq = 1'b1;
    else if (sign_diff) lt = cls_a.sign;
    else if (mag_eq)    eq = 1'b1;
    else                lt = mag_lt ^ cls_a.sign;
  end

  assign decided_exp = reserved_op | any_nan | sign_diff | both_zero | !mag_eq;

  // Final result and invalid flag for the registered operation.
  always_comb begin
    res_data = 32'd0;
    res_nv   = 1'b0;
    case (op_q)
      OP_FEQ: begin
        if (any_nan) res_nv = any_snan;
        else         res_data = {31'd0, eq};
      end
      OP_FLT: begin
        if (any_nan) res_nv = 1'b1;
        else         res_data = {31'd0, lt};
      end
      OP_FLE: begin
        if (any_nan) res_nv = 1'b1;
        else         res_data = {31'd0, lt | eq};
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = any_snan;
        if (both_nan)        res_data = CANON_NAN;
        else if (cls_a.nan)  res_data = b_q;
        else if (cls_b.nan)  res_data = a_q;
        else if (both_zero)  res_data = (op_q == OP_FMIN) ? {cls_a.sign | cls_b.sign, 31'd0}
                                                          : {cls_a.sign & cls_b.sign, 31'd0};
        else if (op_q == OP_FMIN) res_data = (lt | eq) ? a_q : b_q;
        else                      res_data = lt ? b_q : a_q;
      end
      default: res_nv = 1'b1;
    endcase
  end

  // Next-state decode and result-capture strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          accept  = 1'b1;
          state_d = ST_EXP;
        end
      end
      ST_EXP: begin
        if (decided_exp) begin
          load    = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_MAN;
        end
      end
      ST_MAN: begin
        load    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (valid_q && i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; valid rises one cycle after entering RESP.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      tag_q   <= '0;
      data_q  <= 32'd0;
      nv_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == ST_RESP) && !(valid_q && i_rsp_ready);
      if (accept) begin
        op_q  <= i_op;
        tag_q <= i_tag;
      end
      if (load) begin
        data_q <= res_data;
        nv_q   <= res_nv;
      end
    end
  end

  // Operand holding registers, written only on acceptance.
  always_ff @(posedge i_clk) begin
    // NOTE: pure datapath registers skip reset; they are always written before being consumed.
    if (accept) begin
      a_q <= i_rs1;
      b_q <= i_rs2;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = valid_q;
  assign o_rsp_data  = data_q;
  assign o_rsp_tag   = tag_q;
  assign o_nv        = nv_q;

endmodule

// File: tb/tb_fp_cmp_ctrl.sv
// Scoreboard bench for fp_cmp_ctrl: expected responses are queued when a
// request is driven and compared when the response appears.
module tb_fp_cmp_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_op;
  logic [31:0] i_rs1, i_rs2;
  logic [4:0]  i_tag;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_tag;
  logic        o_nv;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        nv;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        nv;
    logic [1:0]  lat;
  } vec_t;

  exp_t sb_q[$];

  fp_cmp_ctrl #(.TAG_W(5), .CANON_NAN(32'h7FC0_0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag), .o_nv(o_nv)
  );

  always #5 i_clk = ~i_clk;

  // Drive one request, return the observed response and latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] d, output logic [4:0] t,
                        output logic nv, output int lat, output bit acc, output bit got);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_op = op; i_rs1 = a; i_rs2 = b; i_tag = tag;
    acc = o_req_ready;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    got = 1'b0; lat = 0; d = '0; t = '0; nv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge i_clk);
      #1;
      if (o_rsp_valid) begin
        lat = i; got = 1'b1;
        d = o_rsp_data; t = o_rsp_tag; nv = o_nv;
        break;
      end
    end
    if (got) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    i_op = '0; i_rs1 = '0; i_rs2 = '0; i_tag = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_rsp_valid); end
    total++; if (o_rsp_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", o_rsp_data); end
    total++; if (o_rsp_tag !== 5'd0) begin bad++; $display("FAIL reset_tag got=%h want=0", o_rsp_tag); end
    total++; if (o_nv !== 1'b0) begin bad++; $display("FAIL reset_nv got=%b want=0", o_nv); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_req_ready); end
  endtask

  task automatic test_ops();
    vec_t v[$];
    logic [31:0] d; logic [4:0] t; logic nv; int lat; bit acc, got;
    exp_t e;
    //                op     a             b             result        nv  lat
    v.push_back('{3'd1, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 1'b0, 2'd2});
    v.push_back('{3'd0, 32'h3F80_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 2'd3});
    v.push_back('{3'd2, 32'h3F80_0000, 32'h3F80_0001, 32'h0000_0001, 1'b0, 2'd3});
    v.push_back('{3'd1, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000, 1'b0, 2'd2});
    v.push_back('{3'd4, 32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0, 2'd2});
    v.push_back('{3'd3, 32'hBF80_0000, 32'hC000_0000, 32'hC000_0000, 1'b0, 2'd2});
    v.push_back('{3'd3, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 2'd2});
    v.push_back('{3'd4, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 2'd2});
    v.push_back('{3'd0, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0, 2'd2});
    v.push_back('{3'd2, 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1, 2'd2});
    v.push_back('{3'd0, 32'h7F80_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 2'd2});
    v.push_back('{3'd4, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 2'd2});
    v.push_back('{3'd3, 32'h7FC0_0000, 32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 2'd2});
    v.push_back('{3'd3, 32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 2'd2});
    v.push_back('{3'd5, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 1'b1, 2'd2});
    v.push_back('{3'd1, 32'h4000_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 2'd2});
    v.push_back('{3'd1, 32'hBF80_0001, 32'hBF80_0000, 32'h0000_0001, 1'b0, 2'd3});
    v.push_back('{3'd4, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002, 1'b0, 2'd3});
    v.push_back('{3'd2, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 1'b0, 2'd3});
    v.push_back('{3'd0, 32'hC000_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 2'd2});
    foreach (v[i]) begin
      sb_q.push_back('{data: v[i].res, tag: 5'(i + 1), nv: v[i].nv, lat: int'(v[i].lat)});
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 1), d, t, nv, lat, acc, got);
      e = sb_q.pop_front();
      total++; if (!acc) begin bad++; $display("FAIL op%0d_accept ready=0 want=1", i); end
      total++;
      if (!got) begin
        bad++; $display("FAIL op%0d_timeout no response within 20 cycles", i);
      end else begin
        if (d !== e.data) begin bad++; $display("FAIL op%0d_data got=%h want=%h", i, d, e.data); end
        total++; if (t !== e.tag) begin bad++; $display("FAIL op%0d_tag got=%h want=%h", i, t, e.tag); end
        total++; if (nv !== e.nv) begin bad++; $display("FAIL op%0d_nv got=%b want=%b", i, nv, e.nv); end
        total++; if (lat != e.lat) begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit got = 1'b0;
    i_rsp_ready = 1'b0;
    sb_q.push_back('{data: 32'h0000_0001, tag: 5'd7, nv: 1'b0, lat: 2});
    @(negedge i_clk);
    i_req_valid = 1'b1; i_op = 3'd1; i_rs1 = 32'h3F80_0000; i_rs2 = 32'h4000_0000; i_tag = 5'd7;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (o_rsp_valid) begin got = 1'b1; break; end
    end
    e = sb_q.pop_front();
    total++;
    if (!got) begin
      bad++; $display("FAIL bp_timeout no response within 20 cycles");
    end else begin
      // A competing request is presented while the response is stalled.
      @(negedge i_clk);
      i_req_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'hC000_0000; i_rs2 = 32'h4040_0000; i_tag = 5'd9;
      for (int c = 0; c < 4; c++) begin
        @(posedge i_clk); #1;
        total++; if (o_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d got=%b want=1", c, o_rsp_valid); end
        total++; if (o_rsp_data !== e.data) begin bad++; $display("FAIL bp_data c%0d got=%h want=%h", c, o_rsp_data, e.data); end
        total++; if (o_rsp_tag !== e.tag) begin bad++; $display("FAIL bp_tag c%0d got=%h want=%h", c, o_rsp_tag, e.tag); end
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got=%b want=0", c, o_req_ready); end
      end
      @(negedge i_clk);
      i_req_valid = 1'b0; i_rsp_ready = 1'b1;
      @(posedge i_clk); #1;
      total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", o_rsp_valid); end
      total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", o_req_ready); end
      for (int c = 0; c < 4; c++) begin
        @(posedge i_clk); #1;
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_phantom c%0d got=%b want=0", c, o_rsp_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [4:0] t; logic nv; int lat; bit acc, got;
    exp_t e;
    i_rsp_ready = 1'b1;
    sb_q.push_back('{data: 32'h0000_0000, tag: 5'd11, nv: 1'b0, lat: 3});
    @(negedge i_clk);
    i_req_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'h3F80_0001; i_rs2 = 32'h3F80_0000; i_tag = 5'd11;
    @(posedge i_clk);            // accept -> EXP
    #1 i_req_valid = 1'b0;
    @(posedge i_clk);            // EXP -> MAN
    #1 i_rst = 1'b1;
    @(posedge i_clk);            // reset applied in MAN
    #1 i_rst = 1'b0;
    sb_q.delete();               // aborted request never responds
    total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", o_rsp_valid); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", o_req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clk); #1;
      total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale c%0d got=%b want=0", c, o_rsp_valid); end
    end
    sb_q.push_back('{data: 32'h0000_0001, tag: 5'd12, nv: 1'b0, lat: 3});
    run_op(3'd2, 32'h3F80_0000, 32'h3F80_0001, 5'd12, d, t, nv, lat, acc, got);
    e = sb_q.pop_front();
    total++;
    if (!acc || !got) begin
      bad++; $display("FAIL rst_mid_recover accept=%0b got=%0b want=1/1", acc, got);
    end else begin
      if (d !== e.data) begin bad++; $display("FAIL rst_mid_recover_data got=%h want=%h", d, e.data); end
      total++; if (t !== e.tag) begin bad++; $display("FAIL rst_mid_recover_tag got=%h want=%h", t, e.tag); end
      total++; if (lat != e.lat) begin bad++; $display("FAIL rst_mid_recover_lat got=%0d want=%0d", lat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
